// File: rtl/alu_arbiter.sv
// Round-robin two-port scheduler in front of a shared 32-bit ALU.
// S1 registers the granted operands into the ALU, and S2 holds one response slot per requester.
module alu_arbiter #(
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0_valid,
   output logic          req0_ready,
   input  logic [CW-1:0] req0_ctl,
   input  logic [DW-1:0] req0_a,
   input  logic [DW-1:0] req0_b,
   input  logic          req1_valid,
   output logic          req1_ready,
   input  logic [CW-1:0] req1_ctl,
   input  logic [DW-1:0] req1_a,
   input  logic [DW-1:0] req1_b,
   output logic          rsp0_valid,
   input  logic          rsp0_ready,
   output logic [DW-1:0] rsp0_data,
   output logic          rsp0_zero,
   output logic          rsp1_valid,
   input  logic          rsp1_ready,
   output logic [DW-1:0] rsp1_data,
   output logic          rsp1_zero,
   output logic [CW-1:0] alu_ctl,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   input  logic [DW-1:0] alu_out,
   input  logic          alu_zero
);

   logic s1_valid;
   logic s1_id;
   logic last_grant;
   logic elig0, elig1;
   logic grant0, grant1;

   // A port is blocked while its op sits in S1 or while its slot is full and not draining
   always_comb begin
      elig0  = req0_valid && !(s1_valid && !s1_id) && (!rsp0_valid || rsp0_ready);
      elig1  = req1_valid && !(s1_valid &&  s1_id) && (!rsp1_valid || rsp1_ready);
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!reset) begin
         if (elig0 && elig1) begin
            grant0 = last_grant;
            grant1 = !last_grant;
         end else begin
            grant0 = elig0;
            grant1 = elig1;
         end
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;

   // S1: ALU input stage
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid   <= 1'b0;
         s1_id      <= 1'b0;
         alu_ctl    <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         last_grant <= 1'b1;
      end else begin
         s1_valid <= grant0 || grant1;
         if (grant0 || grant1) begin
            s1_id      <= grant1;
            last_grant <= grant1;
            alu_ctl    <= grant1 ? req1_ctl : req0_ctl;
            alu_a      <= grant1 ? req1_a   : req0_a;
            alu_b      <= grant1 ? req1_b   : req0_b;
         end
      end
   end

   // S2: response slots; a refill on the same edge takes priority over a drain
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp0_zero  <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
         rsp1_zero  <= 1'b0;
      end else begin
         if (s1_valid && !s1_id) begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= alu_out;
            rsp0_zero  <= alu_zero;
         end else if (rsp0_ready) begin
            rsp0_valid <= 1'b0;
         end
         if (s1_valid && s1_id) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= alu_out;
            rsp1_zero  <= alu_zero;
         end else if (rsp1_ready) begin
            rsp1_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter, with a behavioural MIPS ALU attached to the alu_* ports.
module tb_alu_arbiter;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 6;

   localparam logic [CW-1:0] OP_ADD = 6'h20;
   localparam logic [CW-1:0] OP_SUB = 6'h22;
   localparam logic [CW-1:0] OP_AND = 6'h24;
   localparam logic [CW-1:0] OP_OR  = 6'h25;
   localparam logic [CW-1:0] OP_XOR = 6'h26;
   localparam logic [CW-1:0] OP_NOR = 6'h27;
   localparam logic [CW-1:0] OP_SLT = 6'h2A;
   localparam logic [CW-1:0] OP_BAD = 6'h3F;

   logic          clk = 1'b0;
   logic          reset;
   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [CW-1:0] req0_ctl, req1_ctl;
   logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
   logic          rsp0_valid, rsp0_ready, rsp0_zero;
   logic          rsp1_valid, rsp1_ready, rsp1_zero;
   logic [DW-1:0] rsp0_data, rsp1_data;
   logic [CW-1:0] alu_ctl;
   logic [DW-1:0] alu_a, alu_b, alu_out;
   logic          alu_zero;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.DW(DW), .CW(CW)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
      .rsp0_zero(rsp0_zero),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
      .rsp1_zero(rsp1_zero),
      .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_zero(alu_zero)
   );

   // Reference ALU: unknown codes yield out=0, zero=1
   always_comb begin
      case (alu_ctl)
         OP_ADD:  alu_out = alu_a + alu_b;
         OP_SUB:  alu_out = alu_a - alu_b;
         OP_AND:  alu_out = alu_a & alu_b;
         OP_OR:   alu_out = alu_a | alu_b;
         OP_NOR:  alu_out = ~(alu_a | alu_b);
         OP_XOR:  alu_out = alu_a ^ alu_b;
         OP_SLT:  alu_out = DW'($signed(alu_a) < $signed(alu_b));
         default: alu_out = '0;
      endcase
      alu_zero = (alu_out == '0);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state, with requests present so ready gating is exercised
      reset = 1'b1;
      req0_valid = 1'b1; req0_ctl = OP_ADD; req0_a = 32'h11; req0_b = 32'h22;
      req1_valid = 1'b1; req1_ctl = OP_SUB; req1_a = 32'h33; req1_b = 32'h44;
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      tick();
      tick();
      #1;
      chk("rst_rdy0", 32'(req0_ready), 32'd0);
      chk("rst_rdy1", 32'(req1_ready), 32'd0);
      chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
      chk("rst_rsp0_data", rsp0_data, 32'd0);
      chk("rst_rsp1_data", rsp1_data, 32'd0);
      chk("rst_rsp0_zero", 32'(rsp0_zero), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_ctl", 32'(alu_ctl), 32'd0);

      // Single op: ADD 5+7 on port 0
      reset = 1'b0;
      req1_valid = 1'b0;
      req0_valid = 1'b1; req0_ctl = OP_ADD; req0_a = 32'd5; req0_b = 32'd7;
      #1;
      chk("one_rdy0", 32'(req0_ready), 32'd1);
      chk("one_rdy1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("one_alu_a", alu_a, 32'd5);
      chk("one_alu_b", alu_b, 32'd7);
      chk("one_alu_ctl", 32'(alu_ctl), 32'(OP_ADD));
      chk("one_rsp0_early", 32'(rsp0_valid), 32'd0);
      tick();
      chk("one_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("one_rsp0_data", rsp0_data, 32'd12);
      chk("one_rsp0_zero", 32'(rsp0_zero), 32'd0);
      rsp0_ready = 1'b1;
      tick();
      chk("one_drain_valid", 32'(rsp0_valid), 32'd0);
      chk("one_drain_hold", rsp0_data, 32'd12);

      // Contention: grants alternate 0,1,0,1 from the reset state
      do_reset();
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_ctl = OP_ADD;
      req1_valid = 1'b1; req1_ctl = OP_SUB; req1_a = 32'd50; req1_b = 32'd0;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) begin
            req0_a = 32'(k); req0_b = 32'd100;
         end else begin
            req1_a = 32'd50; req1_b = 32'(k);
         end
         #1;
         chk("cont_rdy0", 32'(req0_ready), 32'(k % 2 == 0));
         chk("cont_rdy1", 32'(req1_ready), 32'(k % 2 == 1));
         if (k >= 1)
            chk("cont_alu_b", alu_b, ((k - 1) % 2 == 0) ? 32'd100 : 32'(k - 1));
         if (k >= 2) begin
            if (k % 2 == 0) begin
               chk("cont_rsp0_valid", 32'(rsp0_valid), 32'd1);
               chk("cont_rsp0_data", rsp0_data, 32'(k + 98));
               chk("cont_rsp1_idle", 32'(rsp1_valid), 32'd0);
            end else begin
               chk("cont_rsp1_valid", 32'(rsp1_valid), 32'd1);
               chk("cont_rsp1_data", rsp1_data, 32'(52 - k));
               chk("cont_rsp0_idle", 32'(rsp0_valid), 32'd0);
            end
         end
         tick();
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      tick();

      // Zero flag and SLT on port 1
      req1_valid = 1'b1; req1_ctl = OP_SUB; req1_a = 32'h9; req1_b = 32'h9;
      #1;
      chk("zf_rdy1", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      tick();
      chk("zf_rsp1_valid", 32'(rsp1_valid), 32'd1);
      chk("zf_rsp1_data", rsp1_data, 32'd0);
      chk("zf_rsp1_zero", 32'(rsp1_zero), 32'd1);
      req1_valid = 1'b1; req1_ctl = OP_SLT; req1_a = 32'h8000_0000; req1_b = 32'd1;
      #1;
      chk("slt_rdy1", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      tick();
      chk("slt_rsp1_data", rsp1_data, 32'd1);
      chk("slt_rsp1_zero", 32'(rsp1_zero), 32'd0);

      // Back-pressure on port 0; port 1 keeps flowing
      rsp0_ready = 1'b0; rsp1_ready = 1'b1;
      req0_valid = 1'b1; req0_ctl = OP_ADD; req0_a = 32'd1; req0_b = 32'd2;
      #1;
      chk("bp_fill_rdy0", 32'(req0_ready), 32'd1);
      tick();
      req0_a = 32'd10; req0_b = 32'd20;
      req1_valid = 1'b1; req1_ctl = OP_OR; req1_a = 32'hF0; req1_b = 32'h0F;
      #1;
      chk("bp_s1_rdy0", 32'(req0_ready), 32'd0);
      chk("bp_s1_rdy1", 32'(req1_ready), 32'd1);
      tick();
      for (int j = 0; j < 4; j++) begin
         chk("bp_hold_rdy0", 32'(req0_ready), 32'd0);
         chk("bp_hold_rdy1", 32'(req1_ready), 32'(j % 2 == 1));
         chk("bp_hold_valid", 32'(rsp0_valid), 32'd1);
         chk("bp_hold_data", rsp0_data, 32'd3);
         tick();
      end
      rsp0_ready = 1'b1;
      #1;
      chk("bp_release_rdy0", 32'(req0_ready), 32'd1);
      chk("bp_release_rdy1", 32'(req1_ready), 32'd0);
      chk("bp_rsp1_data", rsp1_data, 32'hFF);
      tick();
      rsp0_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      chk("bp_alu_a", alu_a, 32'd10);
      chk("bp_alu_b", alu_b, 32'd20);
      chk("bp_freed_valid", 32'(rsp0_valid), 32'd0);
      tick();
      chk("bp_refill_valid", 32'(rsp0_valid), 32'd1);
      chk("bp_refill_data", rsp0_data, 32'd30);
      rsp0_ready = 1'b1;
      tick();
      tick();

      // Reset one cycle after a port-0 handshake
      req0_valid = 1'b1; req0_ctl = OP_ADD; req0_a = 32'd3; req0_b = 32'd4;
      #1;
      chk("rmid_hs_rdy0", 32'(req0_ready), 32'd1);
      tick();
      reset = 1'b1;
      req1_valid = 1'b1; req1_ctl = OP_AND; req1_a = 32'hFF; req1_b = 32'h0F;
      #1;
      chk("rmid_rdy0", 32'(req0_ready), 32'd0);
      chk("rmid_rdy1", 32'(req1_ready), 32'd0);
      tick();
      chk("rmid_rsp0_valid", 32'(rsp0_valid), 32'd0);
      chk("rmid_rsp0_data", rsp0_data, 32'd0);
      chk("rmid_rsp1_data", rsp1_data, 32'd0);
      chk("rmid_alu_a", alu_a, 32'd0);
      chk("rmid_alu_b", alu_b, 32'd0);
      chk("rmid_alu_ctl", 32'(alu_ctl), 32'd0);
      reset = 1'b0;
      #1;
      chk("rmid_tie_rdy0", 32'(req0_ready), 32'd1);
      chk("rmid_tie_rdy1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("rmid_next_rdy1", 32'(req1_ready), 32'd1);
      chk("rmid_no_rsp0", 32'(rsp0_valid), 32'd0);
      tick();
      req1_valid = 1'b0;
      chk("rmid_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("rmid_rsp0_data2", rsp0_data, 32'd7);
      tick();
      chk("rmid_rsp1_valid", 32'(rsp1_valid), 32'd1);
      chk("rmid_rsp1_data2", rsp1_data, 32'h0F);

      // Unknown ctl code on port 0 alongside a normal port-1 op
      req0_valid = 1'b1; req0_ctl = OP_BAD; req0_a = 32'd5; req0_b = 32'd5;
      req1_valid = 1'b1; req1_ctl = OP_ADD; req1_a = 32'd1; req1_b = 32'd1;
      #1;
      chk("bad_rdy0", 32'(req0_ready), 32'd1);
      chk("bad_rdy1", 32'(req1_ready), 32'd0);
      tick();
      req0_valid = 1'b0;
      #1;
      chk("bad_next_rdy1", 32'(req1_ready), 32'd1);
      tick();
      req1_valid = 1'b0;
      chk("bad_rsp0_valid", 32'(rsp0_valid), 32'd1);
      chk("bad_rsp0_data", rsp0_data, 32'd0);
      chk("bad_rsp0_zero", 32'(rsp0_zero), 32'd1);
      tick();
      chk("bad_rsp1_data", rsp1_data, 32'd2);
      chk("bad_rsp1_zero", 32'(rsp1_zero), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
